// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select with deferred redirect under stall,
// halt on EBREAK or illegal target. Define FETCH_PERF_CNT_EN to add the fetch_count output.
module fetch_unit #(
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter int unsigned                MEM_WORDS     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     redirect_valid,
  input  logic                     redirect_is_jalr,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic [DATA_WIDTH-1:0]    instruction_in,
  output logic [ADDRESS_WIDTH-1:0] pc_out,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0]    instruction_out,
  output logic                     inst_valid,
  output logic                     halted,
  output logic                     fault,
  output logic [ADDRESS_WIDTH-1:0] fault_addr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              fetch_count
`endif
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [DATA_WIDTH-1:0] NOP    = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);

  // One extra bit so that PC+4 wrapping past 2^ADDRESS_WIDTH still compares as out of range.
  localparam logic [ADDRESS_WIDTH:0] LIMIT = (ADDRESS_WIDTH + 1)'(64'(MEM_WORDS) * 64'd4);

  logic [1:0]               state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     pend_valid;
  logic [ADDRESS_WIDTH-1:0] pend_target;

  logic [ADDRESS_WIDTH:0]   seq_sum;
  logic [ADDRESS_WIDTH-1:0] redirect_tgt;
  logic [ADDRESS_WIDTH:0]   tgt;
  logic                     tgt_bad;
  logic                     is_run;
  logic                     advance;
  logic                     is_ebreak;

  assign is_run       = (state == ST_RUN);
  assign seq_sum      = {1'b0, pc} + (ADDRESS_WIDTH + 1)'(4);
  assign redirect_tgt = redirect_is_jalr ? {redirect_target[ADDRESS_WIDTH-1:1], 1'b0}
                                         : redirect_target;
  assign is_ebreak    = (instruction_in == EBREAK);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    tgt = seq_sum;
    if (redirect_valid) begin
      tgt = {1'b0, redirect_tgt};
    end else if (pend_valid) begin
      tgt = {1'b0, pend_target};
    end
  end

  assign tgt_bad = (tgt[1:0] != 2'b00) || (tgt >= LIMIT);
  assign advance = is_run && !stall_i && !is_ebreak && !tgt_bad;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      fault       <= 1'b0;
      fault_addr  <= '0;
    end else begin
      case (state)
        ST_INIT: state <= ST_RUN;
        ST_RUN: begin
          if (stall_i) begin
            if (redirect_valid) begin
              pend_valid  <= 1'b1;
              pend_target <= redirect_tgt;
            end
          end else begin
            pend_valid <= 1'b0;
            if (is_ebreak) begin
              state <= ST_HALT;
            end else if (tgt_bad) begin
              state      <= ST_HALT;
              fault      <= 1'b1;
              fault_addr <= tgt[ADDRESS_WIDTH-1:0];
            end else begin
              pc <= tgt[ADDRESS_WIDTH-1:0];
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

  assign pc_out          = pc;
  assign pc_plus4        = seq_sum[ADDRESS_WIDTH-1:0];
  assign inst_valid      = is_run;
  assign instruction_out = is_run ? instruction_in : NOP;
  assign halted          = (state == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (advance && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, redirect, stall with pending redirect,
// jalr alignment, fault and EBREAK halts, and the optional fetch counter.
module tb_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] TAG    = 32'h1230_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid;
  logic        redirect_is_jalr;
  logic [31:0] redirect_target;
  logic [31:0] instruction_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] instruction_out;
  logic        inst_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fault_addr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  logic        ebreak_en;
  logic [31:0] ebreak_pc;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Memory stand-in: word-aligned addresses can never produce the EBREAK encoding by accident.
  assign instruction_in = (ebreak_en && pc_out == ebreak_pc) ? EBREAK : (TAG | pc_out);

  fetch_unit #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(32'h0), .MEM_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .redirect_valid(redirect_valid),
    .redirect_is_jalr(redirect_is_jalr),
    .redirect_target(redirect_target),
    .instruction_in(instruction_in),
    .pc_out(pc_out),
    .pc_plus4(pc_plus4),
    .instruction_out(instruction_out),
    .inst_valid(inst_valid),
    .halted(halted),
    .fault(fault),
    .fault_addr(fault_addr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target, input logic jalr);
    redirect_valid   = 1'b1;
    redirect_is_jalr = jalr;
    redirect_target  = target;
  endtask

  task automatic clear_redirect();
    redirect_valid   = 1'b0;
    redirect_is_jalr = 1'b0;
    redirect_target  = 32'h0;
  endtask

  task automatic expect_run(input string tag, input logic [31:0] pc);
    #1;
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".pc4"}, pc_plus4, pc + 32'd4);
    check({tag, ".valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, ".inst"}, instruction_out, TAG | pc);
    check({tag, ".halted"}, {31'b0, halted}, 32'd0);
  endtask

  task automatic expect_halt(input string tag, input logic [31:0] pc,
                             input logic flt, input logic [31:0] faddr);
    #1;
    check({tag, ".halted"}, {31'b0, halted}, 32'd1);
    check({tag, ".fault"}, {31'b0, fault}, {31'b0, flt});
    check({tag, ".faddr"}, fault_addr, faddr);
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".valid"}, {31'b0, inst_valid}, 32'd0);
    check({tag, ".inst"}, instruction_out, NOP);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    stall_i   = 1'b0;
    ebreak_en = 1'b0;
    ebreak_pc = 32'h0;
    clear_redirect();
    #2;

    // Reset, INIT for one cycle, then sequential fetch.
    do_reset();
    #1;
    check("init.pc", pc_out, 32'h0);
    check("init.valid", {31'b0, inst_valid}, 32'd0);
    check("init.inst", instruction_out, NOP);
    check("init.halted", {31'b0, halted}, 32'd0);
    check("init.fault", {31'b0, fault}, 32'd0);
    check("init.faddr", fault_addr, 32'h0);
    tick(); expect_run("seq0", 32'h0);
    tick(); expect_run("seq4", 32'h4);
    tick(); expect_run("seq8", 32'h8);
    tick(); expect_run("seqC", 32'hC);
    tick(); expect_run("seq10", 32'h10);

    // Plain redirect.
    redirect(32'h40, 1'b0);
    tick(); clear_redirect();
    expect_run("br40", 32'h40);
    tick(); expect_run("br44", 32'h44);

    // Three-cycle stall at 0x20 with a redirect latched in the second stalled cycle.
    redirect(32'h20, 1'b0);
    tick(); clear_redirect();
    expect_run("to20", 32'h20);
    stall_i = 1'b1;
    tick(); expect_run("stall1", 32'h20);
    redirect(32'h80, 1'b0);
    tick(); clear_redirect();
    expect_run("stall2", 32'h20);
    tick(); expect_run("release", 32'h20);
    stall_i = 1'b0;
    tick(); expect_run("pend80", 32'h80);

    // A live redirect on the release cycle beats the pending one.
    stall_i = 1'b1;
    redirect(32'hA0, 1'b0);
    tick(); clear_redirect();
    expect_run("stallA0", 32'h80);
    stall_i = 1'b0;
    redirect(32'h90, 1'b0);
    tick(); clear_redirect();
    expect_run("live90", 32'h90);
    tick(); expect_run("after90", 32'h94);

    // jalr clears bit0; a jalr target still misaligned after that faults.
    redirect(32'h51, 1'b1);
    tick(); clear_redirect();
    expect_run("jalr50", 32'h50);
    redirect(32'h52, 1'b1);
    tick(); clear_redirect();
    expect_halt("jalr52", 32'h50, 1'b1, 32'h52);
    redirect(32'h40, 1'b0);
    tick(); clear_redirect();
    expect_halt("haltheld", 32'h50, 1'b1, 32'h52);

    // Reset clears a fault; sequential fetch off the end of memory faults.
    do_reset();
    #1;
    check("rst2.fault", {31'b0, fault}, 32'd0);
    check("rst2.halted", {31'b0, halted}, 32'd0);
    tick(); expect_run("rst2.run", 32'h0);
    redirect(32'h3FC, 1'b0);
    tick(); clear_redirect();
    expect_run("last", 32'h3FC);
    tick(); expect_halt("overrun", 32'h3FC, 1'b1, 32'h400);

    // Misaligned non-jalr target faults.
    do_reset();
    tick();
    redirect(32'h42, 1'b0);
    tick(); clear_redirect();
    expect_halt("mis42", 32'h0, 1'b1, 32'h42);

    // EBREAK at 0x8: ignored under stall, wins over a simultaneous redirect.
    ebreak_en = 1'b1;
    ebreak_pc = 32'h8;
    do_reset();
    tick(); expect_run("eb0", 32'h0);
    tick(); expect_run("eb4", 32'h4);
    tick(); #1;
    check("eb8.inst", instruction_out, EBREAK);
    check("eb8.valid", {31'b0, inst_valid}, 32'd1);
    stall_i = 1'b1;
    tick(); #1;
    check("ebstall.halted", {31'b0, halted}, 32'd0);
    check("ebstall.pc", pc_out, 32'h8);
    stall_i = 1'b0;
    redirect(32'h40, 1'b0);
    tick(); clear_redirect();
    expect_halt("ebreak", 32'h8, 1'b0, 32'h0);
    ebreak_en = 1'b0;

    // Counter and mid-run reset.
    do_reset();
    tick();
`ifdef FETCH_PERF_CNT_EN
    #1;
    check("cnt.start", fetch_count, 32'd0);
`endif
    for (int i = 0; i < 10; i++) tick();
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    stall_i = 1'b0;
    expect_run("cnt.pc", 32'h28);
`ifdef FETCH_PERF_CNT_EN
    check("cnt.ten", fetch_count, 32'd10);
`endif
    do_reset();
    #1;
    check("midrst.pc", pc_out, 32'h0);
    check("midrst.valid", {31'b0, inst_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("midrst.cnt", fetch_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
